// File: rtl/ball_raster.sv
// ball_raster: per-pixel ball hit test against a double-buffered ball list.
// Software fills the shadow file; it is copied to the active file on each VGA_VS fall.

module ball_raster #(
  parameter int NUM_BALLS = 4,
  parameter int IDX_W     = 2
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             wr_en,
  input  logic [3:0]       wr_addr,
  input  logic [31:0]      wr_data,
  input  logic             VGA_VS,
  input  logic [9:0]       DrawX,
  input  logic [9:0]       DrawY,
  output logic             is_ball,
  output logic [IDX_W-1:0] ball_idx,
  output logic             frame_tick,
  output logic [15:0]      frame_count
);

  localparam int REC_W = 27;

  logic [REC_W-1:0]     shadow_q [NUM_BALLS];
  logic [REC_W-1:0]     shadow_d [NUM_BALLS];
  logic [REC_W-1:0]     active_q [NUM_BALLS];
  logic [REC_W-1:0]     active_d [NUM_BALLS];
  logic                 vs_meta_q, vs_sync_q, vs_prev_q;
  logic                 fall_s;
  logic [9:0]           dxm_q [NUM_BALLS];
  logic [9:0]           dxm_d [NUM_BALLS];
  logic [9:0]           dym_q [NUM_BALLS];
  logic [9:0]           dym_d [NUM_BALLS];
  logic [5:0]           r_q   [NUM_BALLS];
  logic [5:0]           r_d   [NUM_BALLS];
  logic [NUM_BALLS-1:0] v_q, v_d, hit_s;
  logic                 is_ball_q, is_ball_d;
  logic [IDX_W-1:0]     ball_idx_q, ball_idx_d;
  logic                 frame_tick_q, frame_tick_d;
  logic [15:0]          frame_count_q, frame_count_d;

  function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
    logic [10:0] d;
    logic [10:0] m;
    d = {1'b0, a} - {1'b0, b};
    if (d[10]) m = 11'd0 - d;
    else       m = d;
    return m[9:0];
  endfunction

  function automatic logic hit_test(input logic [9:0] dx, input logic [9:0] dy,
                                    input logic [5:0] r, input logic v);
    logic [19:0] dx2;
    logic [19:0] dy2;
    logic [20:0] sum;
    logic [11:0] r2;
    dx2 = 20'(dx) * 20'(dx);
    dy2 = 20'(dy) * 20'(dy);
    sum = 21'(dx2) + 21'(dy2);
    r2  = 12'(r) * 12'(r);
    return v && (sum <= {9'd0, r2});
  endfunction

  // Falling edge of the synchronized vertical sync marks the commit cycle.
  assign fall_s = vs_prev_q & ~vs_sync_q;

  // Register-file next state and stage-1 per-ball distance magnitudes.
  always_comb begin
    for (int i = 0; i < NUM_BALLS; i++) begin
      if (wr_en && (wr_addr == 4'(i))) shadow_d[i] = wr_data[REC_W-1:0];
      else                             shadow_d[i] = shadow_q[i];
      if (fall_s) active_d[i] = shadow_q[i];
      else        active_d[i] = active_q[i];
      dxm_d[i] = abs_diff(DrawX, active_q[i][9:0]);
      dym_d[i] = abs_diff(DrawY, active_q[i][19:10]);
      r_d[i]   = active_q[i][25:20];
      v_d[i]   = active_q[i][26];
    end
  end

  // Stage 2: hit test per ball, OR-reduce and lowest-index priority encode.
  always_comb begin
    hit_s      = '0;
    ball_idx_d = '0;
    for (int i = 0; i < NUM_BALLS; i++) begin
      hit_s[i] = hit_test(dxm_q[i], dym_q[i], r_q[i], v_q[i]);
    end
    is_ball_d = |hit_s;
    for (int i = NUM_BALLS - 1; i >= 0; i--) begin
      if (hit_s[i]) ball_idx_d = IDX_W'(i);
      else          ball_idx_d = ball_idx_d;
    end
    frame_tick_d = fall_s;
    if (fall_s) frame_count_d = frame_count_q + 16'd1;
    else        frame_count_d = frame_count_q;
  end

  // All state: register files, sync chain, pipeline and outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_BALLS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
        dxm_q[i]    <= '0;
        dym_q[i]    <= '0;
        r_q[i]      <= '0;
      end
      v_q           <= '0;
      vs_meta_q     <= 1'b0;
      vs_sync_q     <= 1'b0;
      vs_prev_q     <= 1'b0;
      is_ball_q     <= 1'b0;
      ball_idx_q    <= '0;
      frame_tick_q  <= 1'b0;
      frame_count_q <= 16'd0;
    end else begin
      for (int i = 0; i < NUM_BALLS; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
        dxm_q[i]    <= dxm_d[i];
        dym_q[i]    <= dym_d[i];
        r_q[i]      <= r_d[i];
      end
      v_q           <= v_d;
      vs_meta_q     <= VGA_VS;
      vs_sync_q     <= vs_meta_q;
      vs_prev_q     <= vs_sync_q;
      is_ball_q     <= is_ball_d;
      ball_idx_q    <= ball_idx_d;
      frame_tick_q  <= frame_tick_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign is_ball     = is_ball_q;
  assign ball_idx    = ball_idx_q;
  assign frame_tick  = frame_tick_q;
  assign frame_count = frame_count_q;

endmodule

// File: doc/ball_raster.md
# ball_raster

Per-pixel ball-hit generator that produces `is_ball` (and the index of the ball hit) for the colour mapper from the VGA controller's `DrawX`/`DrawY`. The Nios software writes ball centre and radius records into a shadow register file through an Avalon-exported write port. The shadow file is copied into the active file once per frame, at the start of vertical sync. This keeps ball motion tear-free. A two-stage pipeline evaluates `dx²+dy² <= r²` against every active ball.

## Interface

Parameters:
- `NUM_BALLS`, default 4: number of ball slots (1..16).
- `IDX_W`, default 2: index width, equal to clog2(`NUM_BALLS`) with a minimum of 1.

Ports:
- `Clk` in 1: 50 MHz system clock, the single clock of the block.
- `Reset_n` in 1: reset, asynchronous and active-low.
- `wr_en` in 1: shadow-file write strobe, one write per cycle.
- `wr_addr` in 4: slot index; writes with `wr_addr >= NUM_BALLS` are ignored.
- `wr_data` in 32: record fields are `[9:0]` x, `[19:10]` y, `[25:20]` radius r, `[26]` valid; `[31:27]` are ignored.
- `VGA_VS` in 1: vertical sync from the VGA controller, active-low.
- `DrawX` in 10: current pixel column.
- `DrawY` in 10: current pixel row.
- `is_ball` out 1: the pixel presented 2 cycles earlier lies inside at least one valid ball.
- `ball_idx` out `IDX_W`: lowest-numbered ball hit; 0 when `is_ball` = 0.
- `frame_tick` out 1: one-cycle pulse on the cycle the active file is loaded.
- `frame_count` out 16: number of commits so far; wraps from 0xFFFF to 0.

## Operation

- **Shadow file:** on `wr_en` with a legal address, slot `wr_addr` takes `wr_data[26:0]` at the clock edge.
- **Sync edge detection:** `VGA_VS` passes through a 2-flop synchronizer and then an edge register. A falling edge means a high synchronized value followed by a low one.
- **Commit:** on the cycle a falling edge is detected:
  - every active slot takes its shadow slot;
  - `frame_tick` = 1 for that cycle;
  - `frame_count` increments.
- **Write in the commit cycle:** the commit copies the shadow contents from before that edge. The concurrent write lands in the shadow file only and becomes visible at the next commit.
- **Stage 1 (registered):** per ball, |DrawX − x| and |DrawY − y| are computed as 11-bit signed differences. Each magnitude is stored as 10 bits. The valid bit and r are registered alongside.
- **Stage 2 (registered):** per ball, `hit = valid && (dx² + dy² <= r²)`.
  - dx² and dy² are 20 bits each; their sum is 21 bits; r² is 12 bits, zero-extended for the compare.
  - `is_ball` is the OR of all hits.
  - `ball_idx` is a priority encode giving the lowest index that hit.
- **Edge cases of the hit test:**
  - r = 0 with valid = 1 hits only the exact centre pixel.
  - valid = 0 never hits.
  - Balls overlapping the screen edge need no special handling; off-screen coordinates simply never match.
- **Reset:** asserting `Reset_n` low at any time, including mid-frame or mid-pipeline, asynchronously clears:
  - both register files (all valid bits 0);
  - the synchronizer and edge flops;
  - all pipeline registers;
  - all outputs: `is_ball` = 0, `ball_idx` = 0, `frame_tick` = 0, `frame_count` = 0.
- **After reset release:** the first commit needs a genuine high-to-low `VGA_VS` transition. A `VGA_VS` that is already low at release does not commit.

## Timing

- **Pixel latency:** 2 `Clk` cycles from `DrawX`/`DrawY` to `is_ball`/`ball_idx`. That is one 25 MHz pixel; the colour mapper accepts this fixed 1-pixel horizontal shift.
- **Commit latency:** the active file updates 3 `Clk` edges after `VGA_VS` falls (2 synchronizer flops plus the edge register). `frame_tick` is high on that same cycle.
- **First use of new data:** a pixel presented on the commit cycle is still evaluated against the old active file. The new file applies from the next cycle. All of this happens inside vertical blank, so no visible pixel is affected.
- **Outputs:** all registered; no combinational path from any input to any output.
- **Critical path:** the squares use DSP multipliers. If 50 MHz closure fails, a third stage may be inserted only by revising this specification.

## Test plan

- **Reset values:** hold `Reset_n` low with random `DrawX`/`DrawY` and a toggling `VGA_VS` -> all outputs stay 0; after release, no commit occurs until a real `VGA_VS` fall.
- **Single ball:** write slot 0 = {valid 1, x 100, y 100, r 10}, pulse `VGA_VS` low.
  - `frame_tick` fires once, 3 cycles after the fall; `frame_count` = 1.
  - (110,100) -> `is_ball` = 1 two cycles later.
  - (108,107) has sum 113 > 100 -> `is_ball` = 0.
  - (100,100) -> `is_ball` = 1, `ball_idx` = 0.
- **Shadow isolation:** after the commit, write slot 0 x = 300 without a `VGA_VS` edge -> (100,100) still hits; after the next fall -> (300,100) hits and (100,100) does not.
- **Overlap priority:** slot 1 = {100,100,r 5} and slot 3 = {102,100,r 5}, committed.
  - (104,100) -> `is_ball` = 1, `ball_idx` = 1.
  - (106,100) -> `ball_idx` = 3.
  - Clearing slot 1's valid bit and committing -> (104,100) gives `ball_idx` = 3.
- **Boundary cases:**
  - r = 0 ball at (0,0): only (0,0) hits.
  - Ball at (639,479) with r = 63: (1023,1023) does not hit.
  - `wr_addr` = 15 with `NUM_BALLS` = 4 changes nothing.
  - A write in the commit cycle appears only after the following commit.
  - `frame_count` preloaded by 65536 commits wraps to 0.
- **Mid-frame reset:** commit two balls, then pulse `Reset_n` low for 1 cycle mid-pipeline -> outputs are 0 immediately; no ball hits until the files are rewritten and a new commit occurs.
